// File: rtl/mux8x1_pkg.sv
// Shared constants and types for the 8:1 lane-select primitive.
// NUM_LANES lanes, SEL_W-bit select; sel_t is the select type.
package mux8x1_pkg;

  localparam int NUM_LANES = 8;
  localparam int SEL_W     = 3;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux8x1_comb.sv
// Purely combinational WIDTH-bit 8:1 selector: sel = lane s of i.
// Ports: i (8*WIDTH packed lanes, lane 0 at LSBs), s (select), sel (lane).
module mux8x1_comb
  import mux8x1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [NUM_LANES*WIDTH-1:0] i,
  input  sel_t                       s,
  output logic [WIDTH-1:0]           sel
);

  logic [WIDTH-1:0] lanes [NUM_LANES];

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lanes[k] = i[k*WIDTH +: WIDTH];
  end

  assign sel = lanes[s];

endmodule

// File: rtl/mux8x1_reg.sv
// 8:1 lane select with registered output y and valid flag y_vld.
// Ports: clk, rst_n (async low), en, i, s -> y, y_vld; y_comb if MUX8X1_COMB_OUT_EN.
module mux8x1_reg
  import mux8x1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_LANES*WIDTH-1:0] i,
  input  sel_t                       s,
`ifdef MUX8X1_COMB_OUT_EN
  output logic [WIDTH-1:0]           y_comb,
`endif
  output logic [WIDTH-1:0]           y,
  output logic                       y_vld
);

  logic [WIDTH-1:0] sel;

  mux8x1_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .i   (i),
    .s   (s),
    .sel (sel)
  );

`ifdef MUX8X1_COMB_OUT_EN
  assign y_comb = sel;
`endif

  // y holds when en is low; y_vld only marks the cycle after a capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      y_vld <= 1'b0;
    end else begin
      y_vld <= en;
      if (en) y <= sel;
    end
  end

endmodule

// File: tb/tb_mux8x1_reg.sv
// Directed self-checking bench for mux8x1_reg (WIDTH=1 and WIDTH=4).
// Checks y_comb as well when MUX8X1_COMB_OUT_EN is defined.
module tb_mux8x1_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] i;
  logic [2:0] s;
  logic       y;
  logic       y_vld;

  logic        en4;
  logic [31:0] i4;
  logic [2:0]  s4;
  logic [3:0]  y4;
  logic        y4_vld;
`ifdef MUX8X1_COMB_OUT_EN
  logic        y1c;
  logic [3:0]  y4c;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux8x1_reg #(.WIDTH(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .i      (i),
    .s      (s),
`ifdef MUX8X1_COMB_OUT_EN
    .y_comb (y1c),
`endif
    .y      (y),
    .y_vld  (y_vld)
  );

  mux8x1_reg #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en4),
    .i      (i4),
    .s      (s4),
`ifdef MUX8X1_COMB_OUT_EN
    .y_comb (y4c),
`endif
    .y      (y4),
    .y_vld  (y4_vld)
  );

  typedef struct {
    logic [7:0] i;
    logic [2:0] s;
    logic       en;
    logic       y;
    logic       vld;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'b10100100, 3'b100, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'b11001100, 3'b011, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{8'b01100001, 3'b101, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8'b01000010, 3'b010, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'b10100001, 3'b101, 1'b1, 1'b1, 1'b1};

    en4 = 1'b0; i4 = 32'h0; s4 = 3'd0;

    // reset with capture requested
    #2;
    rst_n = 1'b0; en = 1'b1; i = 8'hFF; s = 3'd0;
    #1;
    chk("rst_y_imm", {31'd0, y}, 0);
    chk("rst_vld_imm", {31'd0, y_vld}, 0);
    chk("rst_y4_imm", {28'd0, y4}, 0);
    edge1();
    edge1();
    chk("rst_y_edge", {31'd0, y}, 0);
    chk("rst_vld_edge", {31'd0, y_vld}, 0);
    rst_n = 1'b1;
    edge1();
    chk("rel_y", {31'd0, y}, 1);
    chk("rel_vld", {31'd0, y_vld}, 1);

    // select sweep table
    for (int k = 0; k < 5; k++) begin
      i = vecs[k].i; s = vecs[k].s; en = vecs[k].en;
      edge1();
      chk($sformatf("vec%0d_y", k), {31'd0, y}, {31'd0, vecs[k].y});
      chk($sformatf("vec%0d_vld", k), {31'd0, y_vld}, {31'd0, vecs[k].vld});
    end

    // one-hot lanes vs every select
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        i = 8'd1 << k; s = 3'(j); en = 1'b1;
        edge1();
        chk($sformatf("oh_k%0d_s%0d", k, j), {31'd0, y},
            (k == j) ? 32'd1 : 32'd0);
      end
    end

    // enable hold
    i = 8'h08; s = 3'd3; en = 1'b1;
    edge1();
    chk("hold_cap_y", {31'd0, y}, 1);
    en = 1'b0; i = 8'h00;
    edge1();
    chk("hold_y", {31'd0, y}, 1);
    chk("hold_vld", {31'd0, y_vld}, 0);
    edge1();
    chk("hold_y2", {31'd0, y}, 1);
    en = 1'b1;
    edge1();
    chk("reen_y", {31'd0, y}, 0);
    chk("reen_vld", {31'd0, y_vld}, 1);

    // back-to-back capture, then input wiggle between edges
    i = 8'h80; s = 3'd7;
    edge1();
    chk("b2b_y", {31'd0, y}, 1);
    chk("b2b_vld", {31'd0, y_vld}, 1);
    i = 8'h00; s = 3'd0;
    #2;
    chk("nogl_y", {31'd0, y}, 1);
    en = 1'b0;

    // async reset mid-cycle
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_y", {31'd0, y}, 0);
    chk("midrst_vld", {31'd0, y_vld}, 0);
    i = 8'hFF; en = 1'b1;
    edge1();
    chk("midrst_edge_y", {31'd0, y}, 0);
    rst_n = 1'b1;

    // WIDTH=4 instance
    i4 = 32'h7654_3210; s4 = 3'd5; en4 = 1'b1;
`ifdef MUX8X1_COMB_OUT_EN
    #1;
    chk("w4_comb", {28'd0, y4c}, 32'h5);
    i = 8'h10; s = 3'd4;
    #1;
    chk("w1_comb", {31'd0, y1c}, 1);
`endif
    edge1();
    chk("w4_s5", {28'd0, y4}, 32'h5);
    chk("w4_vld", {31'd0, y4_vld}, 1);
    s4 = 3'd7;
    edge1();
    chk("w4_s7", {28'd0, y4}, 32'h7);
    s4 = 3'd0;
    edge1();
    chk("w4_s0", {28'd0, y4}, 32'h0);
    en4 = 1'b0; s4 = 3'd6;
    edge1();
    chk("w4_hold", {28'd0, y4}, 32'h0);
    chk("w4_hold_vld", {31'd0, y4_vld}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
